// File: rtl/output_vc_controller_multi.sv
// -----------------------------------------------------------------------------
// output_vc_controller_multi
//
// Per-output-port controller for NUM_VC output virtual channels. It sits after
// the crossbar output of one router port. Each VC keeps:
//   - a credit counter sized for the downstream input buffer, reset full;
//   - an availability flag for the VC allocator.
// Credits come back on a return channel tagged with a VC id. That channel is
// either registered for one cycle (CREDIT_REG=1) or used directly
// (CREDIT_REG=0). Saturating counters raise sticky error flags.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   valid            flit present at the crossbar output this cycle
//   data[DW]         flit; vcid = data[DW-1 -: VCID_W],
//                    type = data[DW-VCID_W-1 -: 2]
//   credit_upd       downstream freed one slot
//   credit_vcid      VC of the returned credit
//   alloc_vc         VC allocator grant (any number of bits); clears
//                    availability
//   out_vc_available VC free for allocation
//   out_vc_ready     VC credit count above CREDIT_LBOUND
//   credit_cnt_o     packed counters, VC v at [v*CNT_W +: CNT_W]
//   err_overflow     sticky: credit returned to a full counter
//   err_underflow    sticky: flit sent on a VC with zero credits
// -----------------------------------------------------------------------------
`ifndef TAIL
`define TAIL 2'b10
`endif

module output_vc_controller_multi #(
  parameter int  NUM_VC        = 4,
  parameter int  VCID_W        = 2,
  parameter int  DW            = 32,
  parameter int  BUF_DEPTH     = 8,
  parameter int  CREDIT_LBOUND = 1,
  parameter int  CREDIT_REG    = 1,
  localparam int CNT_W         = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [DW-1:0]           data,
  input  logic                    credit_upd,
  input  logic [VCID_W-1:0]       credit_vcid,
  input  logic [NUM_VC-1:0]       alloc_vc,
  output logic [NUM_VC-1:0]       out_vc_available,
  output logic [NUM_VC-1:0]       out_vc_ready,
  output logic [NUM_VC*CNT_W-1:0] credit_cnt_o,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LB   = CNT_W'(CREDIT_LBOUND);

  // Flit header fields
  logic [VCID_W-1:0] flit_vcid;
  logic [1:0]        flit_type;
  logic              unused_data;

  assign flit_vcid   = data[DW-1 -: VCID_W];
  assign flit_type   = data[DW-VCID_W-1 -: 2];
  assign unused_data = ^data[DW-VCID_W-3:0];

  // Effective credit return seen by the counters this cycle
  logic              ret_valid;
  logic [VCID_W-1:0] ret_vcid;

  if (CREDIT_REG != 0) begin : g_ret_reg
    logic              cr_valid_q;
    logic [VCID_W-1:0] cr_vcid_q;

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
      if (rst) begin
        cr_valid_q <= 1'b0;
        cr_vcid_q  <= '0;
      end else begin
        cr_valid_q <= credit_upd;
        cr_vcid_q  <= credit_vcid;
      end
    end

    assign ret_valid = cr_valid_q;
    assign ret_vcid  = cr_vcid_q;
  end else begin : g_ret_comb
    assign ret_valid = credit_upd;
    assign ret_vcid  = credit_vcid;
  end

  // Per-VC send / return decode. A vcid of NUM_VC or above matches no VC and
  // is therefore dropped.
  logic [NUM_VC-1:0] send_vec;
  logic [NUM_VC-1:0] ret_vec;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    send_vec = '0;
    ret_vec  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      send_vec[v] = valid     && (flit_vcid == VCID_W'(v));
      ret_vec[v]  = ret_valid && (ret_vcid  == VCID_W'(v));
    end
  end

  // State
  logic [CNT_W-1:0]  cnt_q [NUM_VC];
  logic [CNT_W-1:0]  cnt_d [NUM_VC];
  logic [NUM_VC-1:0] avail_q, avail_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  always_comb begin
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    avail_d = avail_q;
    for (int v = 0; v < NUM_VC; v++) begin
      cnt_d[v] = cnt_q[v];

      // A send and a return in the same cycle cancel out.
      case ({send_vec[v], ret_vec[v]})
        2'b10: begin
          if (cnt_q[v] == '0) unf_d    = 1'b1;
          else                cnt_d[v] = cnt_q[v] - CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[v] == CNT_FULL) ovf_d    = 1'b1;
          else                      cnt_d[v] = cnt_q[v] + CNT_W'(1);
        end
        default: ;
      endcase

      // An allocation grant wins over a tail leaving on the same cycle.
      if (alloc_vc[v])                                  avail_d[v] = 1'b0;
      else if (send_vec[v] && (flit_type == `TAIL))     avail_d[v] = 1'b1;
    end
  end

  // The counters are a handful of flops, not a RAM, so they take a reset
  // value like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= CNT_FULL;
      avail_q <= '1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= cnt_d[v];
      avail_q <= avail_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Outputs straight from the registered state
  always_comb begin
    out_vc_ready = '0;
    credit_cnt_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      out_vc_ready[v]                 = cnt_q[v] > CNT_LB;
      credit_cnt_o[v*CNT_W +: CNT_W] = cnt_q[v];
    end
  end

  assign out_vc_available = avail_q;
  assign err_overflow     = ovf_q;
  assign err_underflow    = unf_q;

endmodule

// File: tb/tb_output_vc_controller_multi.sv
// -----------------------------------------------------------------------------
// tb_output_vc_controller_multi
//
// Drives two copies of the controller from the same inputs: one with a
// registered credit return and one with a combinational return. Both are
// compared every cycle against a behavioural model that keeps plain integer
// credit counts per VC. Directed sequences cover reset, drain, return
// latency, cancellation, saturation, availability and mid-run reset. After
// that comes a long randomized run.
// -----------------------------------------------------------------------------
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_output_vc_controller_multi;

  localparam int NUM_VC    = 4;
  localparam int VCID_W    = 2;
  localparam int DW        = 32;
  localparam int BUF_DEPTH = 8;
  localparam int LBOUND    = 1;
  localparam int CNT_W     = 4;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = `TAIL;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid;
  logic [DW-1:0]           data;
  logic                    credit_upd;
  logic [VCID_W-1:0]       credit_vcid;
  logic [NUM_VC-1:0]       alloc_vc;

  logic [NUM_VC-1:0]       r_avail, c_avail;
  logic [NUM_VC-1:0]       r_ready, c_ready;
  logic [NUM_VC*CNT_W-1:0] r_cnt, c_cnt;
  logic                    r_ovf, c_ovf, r_unf, c_unf;

  always #5 clk = ~clk;

  output_vc_controller_multi #(.CREDIT_REG(1)) dut_reg (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .credit_upd(credit_upd), .credit_vcid(credit_vcid), .alloc_vc(alloc_vc),
    .out_vc_available(r_avail), .out_vc_ready(r_ready), .credit_cnt_o(r_cnt),
    .err_overflow(r_ovf), .err_underflow(r_unf)
  );

  output_vc_controller_multi #(.CREDIT_REG(0)) dut_comb (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .credit_upd(credit_upd), .credit_vcid(credit_vcid), .alloc_vc(alloc_vc),
    .out_vc_available(c_avail), .out_vc_ready(c_ready), .credit_cnt_o(c_cnt),
    .err_overflow(c_ovf), .err_underflow(c_unf)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Index 0 = registered return, 1 = combinational return.
  // ---------------------------------------------------------------------------
  int m_cnt   [2][NUM_VC];
  bit m_avail [2][NUM_VC];
  bit m_ovf   [2];
  bit m_unf   [2];
  bit p_vld;          // credit return presented on the previous cycle
  int p_vc;

  task automatic model_step();
    int send_vc;
    int ret_vc [2];
    send_vc = valid ? int'(data[DW-1 -: VCID_W]) : -1;
    if (send_vc >= NUM_VC) send_vc = -1;
    ret_vc[0] = p_vld ? p_vc : -1;
    ret_vc[1] = credit_upd ? int'(credit_vcid) : -1;
    for (int c = 0; c < 2; c++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        bit s, r;
        if (rst) begin
          m_cnt[c][v]   = BUF_DEPTH;
          m_avail[c][v] = 1'b1;
          continue;
        end
        s = (send_vc == v);
        r = (ret_vc[c] == v);
        if (s && !r) begin
          if (m_cnt[c][v] == 0) m_unf[c] = 1'b1;
          else                  m_cnt[c][v] = m_cnt[c][v] - 1;
        end else if (r && !s) begin
          if (m_cnt[c][v] == BUF_DEPTH) m_ovf[c] = 1'b1;
          else                          m_cnt[c][v] = m_cnt[c][v] + 1;
        end
        if (alloc_vc[v])                                   m_avail[c][v] = 1'b0;
        else if (s && data[DW-VCID_W-1 -: 2] == T_TAIL)    m_avail[c][v] = 1'b1;
      end
      if (rst) begin
        m_ovf[c] = 1'b0;
        m_unf[c] = 1'b0;
      end
    end
    p_vld = rst ? 1'b0 : credit_upd;
    p_vc  = int'(credit_vcid);
  endtask

  function automatic logic [NUM_VC*CNT_W-1:0] exp_cnt(input int c);
    logic [NUM_VC*CNT_W-1:0] r;
    r = '0;
    for (int v = 0; v < NUM_VC; v++) r[v*CNT_W +: CNT_W] = CNT_W'(m_cnt[c][v]);
    return r;
  endfunction

  function automatic logic [NUM_VC-1:0] exp_avail(input int c);
    logic [NUM_VC-1:0] r;
    for (int v = 0; v < NUM_VC; v++) r[v] = m_avail[c][v];
    return r;
  endfunction

  function automatic logic [NUM_VC-1:0] exp_ready(input int c);
    logic [NUM_VC-1:0] r;
    for (int v = 0; v < NUM_VC; v++) r[v] = m_cnt[c][v] > LBOUND;
    return r;
  endfunction

  task automatic compare_all();
    check("reg_cnt",    r_cnt,   exp_cnt(0));
    check("reg_avail",  r_avail, exp_avail(0));
    check("reg_ready",  r_ready, exp_ready(0));
    check("reg_ovf",    r_ovf,   m_ovf[0]);
    check("reg_unf",    r_unf,   m_unf[0]);
    check("comb_cnt",   c_cnt,   exp_cnt(1));
    check("comb_avail", c_avail, exp_avail(1));
    check("comb_ready", c_ready, exp_ready(1));
    check("comb_ovf",   c_ovf,   m_ovf[1]);
    check("comb_unf",   c_unf,   m_unf[1]);
  endtask

  // One clock: the model and the DUTs see the same inputs at the edge, and
  // outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int vc, input logic [1:0] ty,
                       input bit cu, input int cvc, input logic [3:0] al,
                       input bit r);
    valid       = v;
    data        = {VCID_W'(vc), ty, 28'($urandom)};
    credit_upd  = cu;
    credit_vcid = VCID_W'(cvc);
    alloc_vc    = al;
    rst         = r;
  endtask

  task automatic idle();
    drive(1'b0, 0, T_BODY, 1'b0, 0, 4'b0000, 1'b0);
  endtask

  task automatic send(input int vc, input logic [1:0] ty);
    drive(1'b1, vc, ty, 1'b0, 0, 4'b0000, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    p_vld = 1'b0;
    p_vc  = 0;
    for (int c = 0; c < 2; c++) begin
      m_ovf[c] = 1'b0;
      m_unf[c] = 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        m_cnt[c][v]   = 0;
        m_avail[c][v] = 1'b0;
      end
    end

    // Reset defaults
    drive(1'b0, 0, T_BODY, 1'b0, 0, 4'b0000, 1'b1);
    tick();
    tick();
    check("rst_cnt_reg",    r_cnt,   16'h8888);
    check("rst_cnt_comb",   c_cnt,   16'h8888);
    check("rst_avail",      r_avail, 4'b1111);
    check("rst_ready",      c_ready, 4'b1111);
    check("rst_err",        {r_ovf, r_unf, c_ovf, c_unf}, 4'b0000);

    // Drain VC2 down to 1 credit
    for (int i = 0; i < 7; i++) begin
      send(2, T_BODY);
      tick();
    end
    check("drain_cnt",   r_cnt,   16'h8188);
    check("drain_ready", r_ready, 4'b1011);

    // Credit return latency on VC2
    drive(1'b0, 0, T_BODY, 1'b1, 2, 4'b0000, 1'b0);
    tick();
    check("ret_lat_reg_e1",  r_cnt, 16'h8188);
    check("ret_lat_comb_e1", c_cnt, 16'h8288);
    idle();
    tick();
    check("ret_lat_reg_e2",  r_cnt, 16'h8288);

    // Bring VC1 to 5, then send and return together
    for (int i = 0; i < 3; i++) begin
      send(1, T_BODY);
      tick();
    end
    check("vc1_five", c_cnt, 16'h8258);
    drive(1'b1, 1, T_BODY, 1'b1, 1, 4'b0000, 1'b0);
    tick();
    check("cancel_comb", c_cnt, 16'h8258);
    idle();
    tick();
    // Send on VC1 with a return to the full VC3
    drive(1'b1, 1, T_BODY, 1'b1, 3, 4'b0000, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("ovf_sticky", {r_ovf, c_ovf}, 2'b11);

    // Underflow on VC0
    for (int i = 0; i < 9; i++) begin
      send(0, T_BODY);
      tick();
    end
    check("unf_cnt0", c_cnt[3:0], 4'h0);
    check("unf_flag", {r_unf, c_unf}, 2'b11);

    // Availability
    drive(1'b0, 0, T_BODY, 1'b0, 0, 4'b0100, 1'b0);
    tick();
    check("alloc_clear", r_avail, 4'b1011);
    send(2, T_HEAD);
    tick();
    check("head_hold", r_avail, 4'b1011);
    send(2, T_TAIL);
    tick();
    check("tail_set", c_avail, 4'b1111);
    drive(1'b1, 2, T_TAIL, 1'b0, 0, 4'b0100, 1'b0);
    tick();
    check("alloc_beats_tail", r_avail, 4'b1011);

    // Reset while a registered credit is in flight: it must be dropped
    drive(1'b0, 0, T_BODY, 1'b1, 0, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 0, T_BODY, 1'b0, 0, 4'b0000, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check("rst_drops_credit", {r_ovf, r_cnt}, {1'b0, 16'h8888});

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 50,
            int'($urandom_range(0, NUM_VC - 1)),
            2'($urandom),
            $urandom_range(0, 99) < 45,
            int'($urandom_range(0, NUM_VC - 1)),
            ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000,
            $urandom_range(0, 299) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
